// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial datapath and its fetch stage.
package bs_pkg;

  localparam int BS_IW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous level input, followed by a
// registered rising-edge detector on the synchronised value.
module sync_rise (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q & ~prev_q;

endmodule

// File: rtl/bs_fetch.sv
// Instruction fetch and run control for bit_serial: loadable program memory,
// program counter, and the IDLE/START/RUN/DONE sequencer.
module bs_fetch
  import bs_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int IW    = BS_IW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load_we,
  input  logic [AW-1:0] i_load_addr,
  input  logic [IW-1:0] i_load_data,
  input  logic [AW-1:0] i_prog_last,
  input  logic          i_run,
  input  logic          i_con_pcincr,
  output logic [IW-1:0] o_data_instruction,
  output logic          o_start,
  output logic [AW-1:0] o_pc,
  output logic          o_busy,
  output logic          o_done
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          start_q, start_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic          run_rise;
  logic          load_ok;

  sync_rise u_run_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_run),
    .o_rise  (run_rise)
  );

  // Program loading is only allowed while the datapath is not consuming it.
  assign load_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    mem_d = mem_q;
    if (i_load_we && load_ok) begin
      mem_d[i_load_addr] = i_load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_rise) begin
          state_d = ST_START;
          pc_d    = '0;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (i_con_pcincr) begin
          if (pc_q == i_prog_last) begin
            state_d = ST_DONE;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Start pulse comes straight from a flop so bit_serial never sees a decode glitch.
    start_d = (state_d == ST_START);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start_d;
      mem_q   <= mem_d;
    end
  end

  assign o_data_instruction = mem_q[pc_q];
  assign o_pc               = pc_q;
  assign o_start            = start_q;
  assign o_busy             = (state_q == ST_START) || (state_q == ST_RUN);
  assign o_done             = (state_q == ST_DONE);

endmodule
